// File: rtl/instruction_fetch_pkg.sv
// Shared DLX fetch-stage constants and FSM state encoding.
package instruction_fetch_pkg;

  localparam int unsigned DLX_DATA_WIDTH   = 32;
  localparam int unsigned DLX_ADDR_WIDTH   = 32;
  localparam int unsigned DLX_PC_INCREMENT = 4;
  localparam logic [DLX_DATA_WIDTH-1:0] DLX_NOP = 32'h0000_0000;

  // 2-bit fetch FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SKID  = 2'd2,
    ST_DRAIN = 2'd3
  } if_state_t;

endpackage

// File: rtl/instruction_fetch_skid.sv
// One-entry skid buffer holding {instr, pc+4} while decode is stalled.
module instruction_fetch_skid #(
  parameter int unsigned W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic         i_unload,
  input  logic         i_clear,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data,
  output logic         o_full
);

  logic [W-1:0] r_data;
  logic         r_full;

  // Capture/release the single entry; clear wins over load, load over unload
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
      r_full <= 1'b0;
    end else if (i_clear) begin
      r_full <= 1'b0;
    end else if (i_load) begin
      r_data <= i_data;
      r_full <= 1'b1;
    end else if (i_unload) begin
      r_full <= 1'b0;
    end
  end

  assign o_data = r_data;
  assign o_full = r_full;

endmodule

// File: rtl/instruction_fetch.sv
// DLX IF stage: PC register, fetch FSM, IF/ID register and redirect-target latch.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DLX_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH   = DLX_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
  parameter int unsigned PC_INCREMENT = DLX_PC_INCREMENT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_in,
  input  logic                  flush_in,
  input  logic [ADDR_WIDTH-1:0] branch_target_in,
  output logic                  imem_req_out,
  output logic [ADDR_WIDTH-1:0] imem_addr_out,
  input  logic                  imem_ready_in,
  input  logic [DATA_WIDTH-1:0] imem_data_in,
  output logic [DATA_WIDTH-1:0] instruction_out,
  output logic [ADDR_WIDTH-1:0] pc_plus4_out,
  output logic                  valid_out
);

  localparam int unsigned SKID_W = DATA_WIDTH + ADDR_WIDTH;

  if_state_t             r_state;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] r_target;
  logic                  r_req;
  logic [DATA_WIDTH-1:0] r_instr;
  logic [ADDR_WIDTH-1:0] r_pc4;
  logic                  r_valid;

  logic [ADDR_WIDTH-1:0] w_pc_next;
  logic                  w_skid_load;
  logic                  w_skid_unload;
  logic                  w_skid_clear;
  logic                  w_skid_full;
  logic [SKID_W-1:0]     w_skid_data;

  // Sequential address; wraps modulo 2^ADDR_WIDTH
  assign w_pc_next = r_pc + ADDR_WIDTH'(PC_INCREMENT);

  // Skid control decoded from the current state and this cycle's inputs
  assign w_skid_load   = (r_state == ST_FETCH) && imem_ready_in && stall_in && !flush_in;
  assign w_skid_unload = (r_state == ST_SKID) && !stall_in && !flush_in;
  assign w_skid_clear  = (r_state == ST_SKID) && flush_in;

  instruction_fetch_skid #(
    .W (SKID_W)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_skid_load),
    .i_unload (w_skid_unload),
    .i_clear  (w_skid_clear),
    .i_data   ({imem_data_in, w_pc_next}),
    .o_data   (w_skid_data),
    .o_full   (w_skid_full)
  );

  // Fetch FSM with PC, IF/ID register and request all updated in one place
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_pc     <= RESET_PC;
      r_target <= RESET_PC;
      r_req    <= 1'b0;
      r_instr  <= DATA_WIDTH'(DLX_NOP);
      r_pc4    <= RESET_PC;
      r_valid  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_req   <= 1'b1;
          r_state <= ST_FETCH;
        end
        ST_FETCH: begin
          if (flush_in) begin
            r_valid <= 1'b0;
            if (imem_ready_in) begin
              r_pc <= branch_target_in;
            end else begin
              // outstanding request must complete first
              r_target <= branch_target_in;
              r_state  <= ST_DRAIN;
            end
          end else if (imem_ready_in) begin
            r_pc <= w_pc_next;
            if (stall_in) begin
              r_req   <= 1'b0;
              r_state <= ST_SKID;
            end else begin
              r_instr <= imem_data_in;
              r_pc4   <= w_pc_next;
              r_valid <= 1'b1;
            end
          end else if (!stall_in) begin
            // decode consumed the current word and nothing new arrived
            r_valid <= 1'b0;
          end
        end
        ST_SKID: begin
          if (flush_in) begin
            r_valid <= 1'b0;
            r_pc    <= branch_target_in;
            r_req   <= 1'b1;
            r_state <= ST_FETCH;
          end else if (!stall_in) begin
            r_instr <= w_skid_data[SKID_W-1:ADDR_WIDTH];
            r_pc4   <= w_skid_data[ADDR_WIDTH-1:0];
            r_valid <= w_skid_full;
            r_req   <= 1'b1;
            r_state <= ST_FETCH;
          end
        end
        ST_DRAIN: begin
          r_valid <= 1'b0;
          if (flush_in) begin
            r_target <= branch_target_in;
          end
          if (imem_ready_in) begin
            r_pc    <= flush_in ? branch_target_in : r_target;
            r_state <= ST_FETCH;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req_out    = r_req;
  assign imem_addr_out   = r_pc;
  assign instruction_out = r_instr;
  assign pc_plus4_out    = r_pc4;
  assign valid_out       = r_valid;

endmodule
